// File: rtl/lcd_refresh_ctrl_pkg.sv
// Shared constants and types for the character-LCD refresh controller:
// HD44780 command bytes, screen geometry, FSM encodings and sizing helpers.
package lcd_refresh_ctrl_pkg;

  localparam logic [7:0] CMD_FUNC  = 8'h38;
  localparam logic [7:0] CMD_DISP  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_CLR   = 8'h01;
  localparam logic [7:0] ADDR_L1   = 8'h80;
  localparam logic [7:0] ADDR_L2   = 8'hC0;

  localparam int LINE_LEN   = 16;
  localparam int SCREEN_LEN = 32;

  localparam logic [1:0] LAST_INIT_CMD = 2'd3;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    ADDR,
    FETCH,
    WRITE,
    BUSW
  } state_t;

  typedef enum logic [1:0] {
    BW_IDLE,
    BW_SETUP,
    BW_ENABLE,
    BW_HOLD
  } bw_phase_t;

  // Counter width able to hold the largest of the long delays.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] n);
    case (n)
      2'd0:    return CMD_FUNC;
      2'd1:    return CMD_DISP;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_refresh_ctrl_if.sv
// Signal bundle between the refresh controller, the display-mode block
// (index/char) and the LCD pins.
interface lcd_refresh_ctrl_if;
  import lcd_refresh_ctrl_pkg::*;

  logic [7:0] char_in;
  logic [4:0] index;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;
  logic       init_done;
  logic       frame_done;

  modport master (
    input  char_in,
    output index, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done
  );

  modport slave (
    output char_in,
    input  index, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done
  );

endinterface

// File: rtl/lcd_refresh_ctrl_bus_writer.sv
// One HD44780 bus write: present rs/data, pulse E for EN_CYC cycles, then
// keep E low for the requested wait; done fires in the last wait cycle.
module lcd_bus_writer
  import lcd_refresh_ctrl_pkg::*;
#(
  parameter int CNT_W  = 17,
  parameter int EN_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rs,
  input  logic [7:0]       data,
  input  logic [CNT_W-1:0] wait_len,
  output logic             done,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic [7:0]       lcd_data
);

  bw_phase_t        phase_reg, phase_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] wait_reg, wait_next;
  logic             e_reg, e_next;
  logic             rs_reg, rs_next;
  logic [7:0]       data_reg, data_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_reg <= BW_IDLE;
      cnt_reg   <= '0;
      wait_reg  <= '0;
      e_reg     <= 1'b0;
      rs_reg    <= 1'b0;
      data_reg  <= 8'h00;
    end else begin
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
      wait_reg  <= wait_next;
      e_reg     <= e_next;
      rs_reg    <= rs_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    phase_next = phase_reg;
    cnt_next   = cnt_reg;
    wait_next  = wait_reg;
    e_next     = e_reg;
    rs_next    = rs_reg;
    data_next  = data_reg;
    case (phase_reg)
      BW_IDLE: begin
        if (start) begin
          rs_next    = rs;
          data_next  = data;
          wait_next  = wait_len;
          phase_next = BW_SETUP;
        end
      end
      BW_SETUP: begin
        cnt_next   = '0;
        e_next     = 1'b1;
        phase_next = BW_ENABLE;
      end
      BW_ENABLE: begin
        if (cnt_reg == CNT_W'(EN_CYC - 1)) begin
          cnt_next   = '0;
          e_next     = 1'b0;
          phase_next = BW_HOLD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      BW_HOLD: begin
        if (done) begin
          cnt_next   = '0;
          phase_next = BW_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: phase_next = BW_IDLE;
    endcase
  end

  assign done     = (phase_reg == BW_HOLD) && (cnt_reg == (wait_reg - CNT_W'(1)));
  assign lcd_e    = e_reg;
  assign lcd_rs   = rs_reg;
  assign lcd_data = data_reg;

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Power-up init of a 16x2 character LCD followed by continuous full-screen
// refresh from the display-mode block's index/char lookup.
module lcd_refresh_ctrl
  import lcd_refresh_ctrl_pkg::*;
#(
  parameter int PWRUP_CYC = 20000,
  parameter int EN_CYC    = 8,
  parameter int WAIT_CYC  = 2000,
  parameter int CLR_CYC   = 80000,
  parameter int FETCH_CYC = 2
) (
  input logic               clk,
  input logic               rst,
  lcd_refresh_ctrl_if.master lcd
);

  localparam int CNT_W = cnt_width(PWRUP_CYC, CLR_CYC, WAIT_CYC);

  state_t           state_reg, state_next;
  state_t           caller_reg, caller_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       cmd_idx_reg, cmd_idx_next;
  logic [4:0]       index_reg, index_next;
  logic [7:0]       char_reg, char_next;
  logic             init_done_reg, init_done_next;
  logic             frame_done_reg, frame_done_next;

  logic             bw_start;
  logic             bw_rs;
  logic [7:0]       bw_data;
  logic [CNT_W-1:0] bw_wait;
  logic             bw_done;

  lcd_bus_writer #(
    .CNT_W  (CNT_W),
    .EN_CYC (EN_CYC)
  ) u_bus_writer (
    .clk      (clk),
    .rst      (rst),
    .start    (bw_start),
    .rs       (bw_rs),
    .data     (bw_data),
    .wait_len (bw_wait),
    .done     (bw_done),
    .lcd_e    (lcd.lcd_e),
    .lcd_rs   (lcd.lcd_rs),
    .lcd_data (lcd.lcd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= PWRUP;
      caller_reg     <= PWRUP;
      cnt_reg        <= '0;
      cmd_idx_reg    <= 2'd0;
      index_reg      <= 5'd0;
      char_reg       <= 8'h00;
      init_done_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      caller_reg     <= caller_next;
      cnt_reg        <= cnt_next;
      cmd_idx_reg    <= cmd_idx_next;
      index_reg      <= index_next;
      char_reg       <= char_next;
      init_done_reg  <= init_done_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    caller_next     = caller_reg;
    cnt_next        = cnt_reg;
    cmd_idx_next    = cmd_idx_reg;
    index_next      = index_reg;
    char_next       = char_reg;
    init_done_next  = init_done_reg;
    frame_done_next = 1'b0;
    bw_start        = 1'b0;
    bw_rs           = 1'b0;
    bw_data         = 8'h00;
    bw_wait         = CNT_W'(WAIT_CYC);
    case (state_reg)
      PWRUP: begin
        if (cnt_reg == CNT_W'(PWRUP_CYC - 1)) begin
          cnt_next   = '0;
          state_next = INIT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      INIT: begin
        bw_start    = 1'b1;
        bw_data     = init_cmd(cmd_idx_reg);
        // Clear-display needs a much longer settle time than other commands.
        if (cmd_idx_reg == LAST_INIT_CMD) bw_wait = CNT_W'(CLR_CYC);
        caller_next = INIT;
        state_next  = BUSW;
      end
      ADDR: begin
        bw_start    = 1'b1;
        bw_data     = index_reg[4] ? ADDR_L2 : ADDR_L1;
        caller_next = ADDR;
        state_next  = BUSW;
      end
      FETCH: begin
        if (cnt_reg == CNT_W'(FETCH_CYC - 1)) begin
          char_next  = lcd.char_in;
          cnt_next   = '0;
          state_next = WRITE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WRITE: begin
        bw_start    = 1'b1;
        bw_rs       = 1'b1;
        bw_data     = char_reg;
        caller_next = WRITE;
        state_next  = BUSW;
      end
      BUSW: begin
        if (bw_done) begin
          cnt_next = '0;
          case (caller_reg)
            INIT: begin
              if (cmd_idx_reg == LAST_INIT_CMD) begin
                init_done_next = 1'b1;
                cmd_idx_next   = 2'd0;
                index_next     = 5'd0;
                state_next     = ADDR;
              end else begin
                cmd_idx_next = cmd_idx_reg + 1'b1;
                state_next   = INIT;
              end
            end
            ADDR: state_next = FETCH;
            WRITE: begin
              if (index_reg == 5'(SCREEN_LEN - 1)) begin
                index_next      = 5'd0;
                frame_done_next = 1'b1;
                state_next      = ADDR;
              end else if (index_reg == 5'(LINE_LEN - 1)) begin
                index_next = 5'(LINE_LEN);
                state_next = ADDR;
              end else begin
                index_next = index_reg + 1'b1;
                state_next = FETCH;
              end
            end
            default: state_next = PWRUP;
          endcase
        end
      end
      default: state_next = PWRUP;
    endcase
  end

  assign lcd.index      = index_reg;
  assign lcd.lcd_rw     = 1'b0;
  assign lcd.init_done  = init_done_reg;
  assign lcd.frame_done = frame_done_reg;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed, table-driven bench for lcd_refresh_ctrl with shortened timing:
// init sequence, three refresh frames, char sampling point and mid-write reset.
module tb_lcd_refresh_ctrl;

  localparam int P  = 10;
  localparam int EN = 2;
  localparam int WT = 4;
  localparam int CL = 8;
  localparam int FT = 2;
  localparam int LIM = 200;
  localparam int NV  = 4 + 3 * 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_refresh_ctrl_if bus();

  lcd_refresh_ctrl #(
    .PWRUP_CYC (P),
    .EN_CYC    (EN),
    .WAIT_CYC  (WT),
    .CLR_CYC   (CL),
    .FETCH_CYC (FT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lcd (bus)
  );

  // Display-mode model: either 30h+index, or a value that advances every
  // cycle after an index change (exposes the exact sampling cycle).
  logic       age_mode = 1'b0;
  int         age = 0;
  logic [4:0] idx_seen = 5'd0;
  assign bus.char_in = age_mode ? (8'h60 + 8'(age)) : (8'h30 + {3'b000, bus.index});

  always @(negedge clk) begin
    if (bus.index != idx_seen) begin
      idx_seen = bus.index;
      age = 0;
    end else if (age < 31) begin
      age = age + 1;
    end
  end

  int rw_viol = 0;
  always @(negedge clk) if (bus.lcd_rw !== 1'b0) rw_viol++;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
    logic [4:0] idx;
    logic       init_done;
    int         fd;
  } vec_t;

  vec_t vecs [NV];

  // Positioned at a negedge: counts low samples up to E rise, then high samples.
  task automatic get_write(output int gap, output int width, output logic rs_o,
                           output logic [7:0] data_o, output logic [4:0] idx_o,
                           output logic idone_o, output int fd_cnt, output int fd_idx,
                           output int unstable, output bit tmo);
    gap = 0; width = 0; fd_cnt = 0; fd_idx = -1; unstable = 0; tmo = 1'b0;
    rs_o = 1'b0; data_o = 8'h00; idx_o = 5'd0; idone_o = 1'b0;
    while (bus.lcd_e !== 1'b1) begin
      if (bus.frame_done === 1'b1) begin fd_cnt++; fd_idx = int'(bus.index); end
      gap++;
      if (gap > LIM) begin tmo = 1'b1; return; end
      @(negedge clk);
    end
    rs_o    = bus.lcd_rs;
    data_o  = bus.lcd_data;
    idx_o   = bus.index;
    idone_o = bus.init_done;
    while (bus.lcd_e === 1'b1) begin
      if (bus.frame_done === 1'b1) begin fd_cnt++; fd_idx = int'(bus.index); end
      if (bus.lcd_rs !== rs_o || bus.lcd_data !== data_o) unstable++;
      width++;
      if (width > LIM) begin tmo = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input int i);
    int gap, width, fd_cnt, fd_idx, unstable;
    logic rs_a, id_a;
    logic [7:0] d_a;
    logic [4:0] ix_a;
    bit tmo;
    vec_t v;
    v = vecs[i];
    get_write(gap, width, rs_a, d_a, ix_a, id_a, fd_cnt, fd_idx, unstable, tmo);
    $display("write %0d: rs=%0d data=%02h idx=%0d init_done=%0d gap=%0d width=%0d fd=%0d",
             i, rs_a, d_a, ix_a, id_a, gap, width, fd_cnt);
    check($sformatf("v%0d timeout", i), int'(tmo), 0);
    check($sformatf("v%0d gap", i), gap, v.gap);
    check($sformatf("v%0d e_width", i), width, EN);
    check($sformatf("v%0d rs", i), int'(rs_a), int'(v.rs));
    check($sformatf("v%0d data", i), int'(d_a), int'(v.data));
    check($sformatf("v%0d index", i), int'(ix_a), int'(v.idx));
    check($sformatf("v%0d init_done", i), int'(id_a), int'(v.init_done));
    check($sformatf("v%0d frame_done_cycles", i), fd_cnt, v.fd);
    if (v.fd != 0) check($sformatf("v%0d index_at_frame_done", i), fd_idx, 0);
    check($sformatf("v%0d bus_stable_while_e", i), unstable, 0);
  endtask

  initial begin
    int n;
    int guard;
    logic [7:0] d;

    // Expected write stream; gap = E-low samples before each E pulse.
    vecs[0] = '{1'b0, 8'h38, P + 1, 5'd0, 1'b0, 0};
    vecs[1] = '{1'b0, 8'h0C, WT + 2, 5'd0, 1'b0, 0};
    vecs[2] = '{1'b0, 8'h06, WT + 2, 5'd0, 1'b0, 0};
    vecs[3] = '{1'b0, 8'h01, WT + 2, 5'd0, 1'b0, 0};
    n = 4;
    for (int f = 0; f < 3; f++) begin
      vecs[n] = '{1'b0, 8'h80, (f == 0) ? CL + 2 : WT + 2, 5'd0, 1'b1, (f == 0) ? 0 : 1};
      n++;
      for (int p = 0; p < 32; p++) begin
        if (p == 16) begin
          vecs[n] = '{1'b0, 8'hC0, WT + 2, 5'd16, 1'b1, 0};
          n++;
        end
        if (f < 2) d = 8'h30 + 8'(p);
        else if (p == 0 || p == 16) d = 8'h60 + 8'(2 + EN + WT + FT - 1);
        else d = 8'h60 + 8'(FT - 1);
        vecs[n] = '{1'b1, d, WT + FT + 2, 5'(p), 1'b1, 0};
        n++;
      end
    end

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset lcd_e", int'(bus.lcd_e), 0);
    check("reset index", int'(bus.index), 0);
    check("reset lcd_rs", int'(bus.lcd_rs), 0);
    check("reset lcd_data", int'(bus.lcd_data), 0);
    check("reset init_done", int'(bus.init_done), 0);
    check("reset frame_done", int'(bus.frame_done), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (i == 4 + 2 * 34) age_mode = 1'b1;
      run_vec(i);
    end

    // Reset while E is high at position 20, then the whole init must replay.
    guard = 0;
    while (!(bus.index == 5'd20 && bus.lcd_e === 1'b1) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("reach index20 with e high", int'(guard < 2000), 1);
    rst = 1'b0;
    #1;
    check("midrst lcd_e", int'(bus.lcd_e), 0);
    check("midrst index", int'(bus.index), 0);
    check("midrst lcd_rs", int'(bus.lcd_rs), 0);
    check("midrst lcd_data", int'(bus.lcd_data), 0);
    check("midrst init_done", int'(bus.init_done), 0);
    check("midrst frame_done", int'(bus.frame_done), 0);
    repeat (3) @(negedge clk);
    check("midrst held lcd_e", int'(bus.lcd_e), 0);
    age_mode = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_vec(i);

    check("lcd_rw always 0", rw_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
